// File: rtl/vga_pkg.sv
// Shared 640x480@60 VGA timing constants and coordinate window decode,
// importable by both the timing generator and the character renderer.
package vga_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned FRAME_W = 16;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;
  localparam int unsigned CLK_DIV_DEF  = 4;

  localparam int unsigned H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  typedef logic [COORD_W-1:0] coord_t;

  // True when lo <= v < hi, unsigned.
  function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/pix_strobe.sv
// Clock divider producing a one-clk pixel strobe every CLK_DIV clk cycles.
module pix_strobe #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pix_stb
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;
  logic [DW-1:0] div_nxt;

  always_comb begin
    div_nxt = div + DW'(1);
    if (div == DIV_LAST) div_nxt = '0;
  end

  // Strobe is registered alongside the divider so it is high exactly while div == DIV_LAST.
  always_ff @(posedge clk) begin
    if (rst) begin
      div     <= '0;
      pix_stb <= 1'b0;
    end else begin
      div     <= div_nxt;
      pix_stb <= (div_nxt == DIV_LAST);
    end
  end

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing: pixel/line counters, sync and display-enable decode,
// line/frame start pulses and a free-running frame counter.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter int unsigned CLK_DIV  = CLK_DIV_DEF
) (
  input  logic               clk,
  input  logic               rst,
  output logic [COORD_W-1:0] sx,
  output logic [COORD_W-1:0] sy,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic               pix_stb,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam coord_t H_ACT    = COORD_W'(H_ACTIVE);
  localparam coord_t V_ACT    = COORD_W'(V_ACTIVE);
  localparam coord_t H_LAST   = COORD_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam coord_t V_LAST   = COORD_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam coord_t HS_BEGIN = COORD_W'(H_ACTIVE + H_FP);
  localparam coord_t HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS_BEGIN = COORD_W'(V_ACTIVE + V_FP);
  localparam coord_t VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  coord_t             sx_nxt;
  coord_t             sy_nxt;
  logic [FRAME_W-1:0] frame_cnt_nxt;

  pix_strobe #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_strobe (
    .clk     (clk),
    .rst     (rst),
    .pix_stb (pix_stb)
  );

  // Raster advance: one pixel per strobe, wrapping line and frame.
  always_comb begin
    sx_nxt        = sx;
    sy_nxt        = sy;
    frame_cnt_nxt = frame_cnt;
    if (pix_stb) begin
      if (sx == H_LAST) begin
        sx_nxt = '0;
        if (sy == V_LAST) begin
          sy_nxt        = '0;
          frame_cnt_nxt = frame_cnt + FRAME_W'(1);
        end else begin
          sy_nxt = sy + COORD_W'(1);
        end
      end else begin
        sx_nxt = sx + COORD_W'(1);
      end
    end
  end

  // Syncs and de decode the next coordinates so they line up with sx/sy.
  always_ff @(posedge clk) begin
    if (rst) begin
      sx        <= '0;
      sy        <= '0;
      frame_cnt <= '0;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
      de        <= 1'b1;
    end else begin
      sx        <= sx_nxt;
      sy        <= sy_nxt;
      frame_cnt <= frame_cnt_nxt;
      hsync     <= !in_window(sx_nxt, HS_BEGIN, HS_END);
      vsync     <= !in_window(sy_nxt, VS_BEGIN, VS_END);
      de        <= (sx_nxt < H_ACT) && (sy_nxt < V_ACT);
    end
  end

  assign line_start  = pix_stb && (sx == '0);
  assign frame_start = pix_stb && (sx == '0) && (sy == '0);

endmodule
